ppa_add_pipe: RTL and testbench

Pipelined, parametrised parallel-prefix adder/subtractor for the FP datapath (FP MAC significand sum, FP adder alignment path). Generalises the combinational Kogge-Stone adder: selectable prefix topology, add/subtract mode with carry-in, and a configurable number of pipeline stages behind a valid/ready handshake, so wide significand adds (74 bits and up) meet timing without changing surrounding control.

---
 rtl/ppa_pkg.sv | 37 +++
 rtl/ppa_level.sv | 23 ++
 rtl/ppa_add_pipe.sv | 123 ++++++++++++
 tb/tb_ppa_add_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppa_pkg.sv
// ppa_pkg: prefix-network types and elaboration-time helpers shared by the adder pipeline.
package ppa_pkg;

    typedef enum logic [1:0] {ARCH_KSA, ARCH_SKL, ARCH_BK} arch_e;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int prefix_levels(arch_e arch, int width);
        return (arch == ARCH_BK) ? 2 * $clog2(width) - 1 : $clog2(width);
    endfunction

    function automatic int reg_after_level(int k, int stages, int levels);
        return (k * levels) / stages;
    endfunction

    function automatic logic has_reg(int level, int stages, int levels);
        for (int k = 1; k < stages; k++)
            if (reg_after_level(k, stages, levels) == level) return 1'b1;
        return 1'b0;
    endfunction

    // Bit whose (G,P) bit i absorbs at a level, or -1 when bit i passes through.
    function automatic int partner(arch_e arch, int lvl, int i, int width);
        int l0;
        int d;
        l0 = $clog2(width);
        if (arch == ARCH_KSA) return (i >= (1 << lvl)) ? i - (1 << lvl) : -1;
        if (arch == ARCH_SKL) return (((i >> lvl) & 1) == 1) ? ((i >> lvl) << lvl) - 1 : -1;
        if (lvl < l0) return (((i + 1) % (1 << (lvl + 1))) == 0) ? i - (1 << lvl) : -1;
        d = 2 * l0 - 2 - lvl;
        return (((i + 1) % (1 << (d + 1))) == (1 << d) && i >= (1 << (d + 1))) ? i - (1 << d) : -1;
    endfunction

endpackage

// File: rtl/ppa_level.sv
// ppa_level: one combinational (G,P) combine level of the selected prefix network.
module ppa_level
    import ppa_pkg::*;
#(
    parameter int    WIDTH = 74,
    parameter arch_e ARCH  = ARCH_KSA,
    parameter int    LEVEL = 0
) (
    input  gp_t [WIDTH-1:0] x,
    output gp_t [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int J = partner(ARCH, LEVEL, i, WIDTH);
        if (J >= 0) begin : g_op
            assign y[i].g = x[i].g | (x[i].p & x[J].g);
            assign y[i].p = x[i].p & x[J].p;
        end else begin : g_pass
            assign y[i] = x[i];
        end
    end

endmodule

// File: rtl/ppa_add_pipe.sv
// ppa_add_pipe: pipelined parallel-prefix adder/subtractor with a single global stall enable.
module ppa_add_pipe
    import ppa_pkg::*;
#(
    parameter int    WIDTH  = 74,
    parameter int    STAGES = 2,
    parameter arch_e ARCH   = ARCH_KSA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    localparam int L = prefix_levels(ARCH, WIDTH);

    logic             en;
    logic             c0;
    logic             p_unused;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] pre_g;
    logic [WIDTH-1:0] gv;
    logic [WIDTH-1:0] sum;
    gp_t  [WIDTH-1:0] pre_gp;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign b_eff    = sub ? ~in2 : in2;
    assign c0       = sub | cin;
    assign pre_p    = in1 ^ b_eff;
    assign pre_g    = in1 & b_eff;

    // Carry-in is absorbed into bit 0's generate so the prefix spans only WIDTH bits.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pre_gp[i].g = pre_g[i];
            pre_gp[i].p = pre_p[i];
        end
        pre_gp[0].g = pre_g[0] | (pre_p[0] & c0);
    end

    for (genvar b = 0; b <= L; b++) begin : bnd
        gp_t  [WIDTH-1:0] gp_d;
        gp_t  [WIDTH-1:0] gp_q;
        logic [WIDTH-1:0] bp_d;
        logic [WIDTH-1:0] bp_q;
        logic             ci_d;
        logic             ci_q;
        logic             v_d;
        logic             v_q;
        if (b == 0) begin : g_src
            assign gp_d = pre_gp;
            assign bp_d = pre_p;
            assign ci_d = c0;
            assign v_d  = in_valid;
        end else begin : g_lvl
            ppa_level #(
                .WIDTH(WIDTH),
                .ARCH (ARCH),
                .LEVEL(b - 1)
            ) u_level (
                .x(bnd[b-1].gp_q),
                .y(gp_d)
            );
            assign bp_d = bnd[b-1].bp_q;
            assign ci_d = bnd[b-1].ci_q;
            assign v_d  = bnd[b-1].v_q;
        end
        if (has_reg(b, STAGES, L)) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gp_q <= '0;
                    bp_q <= '0;
                    ci_q <= 1'b0;
                    v_q  <= 1'b0;
                end else if (en) begin
                    gp_q <= gp_d;
                    bp_q <= bp_d;
                    ci_q <= ci_d;
                    v_q  <= v_d;
                end
            end
        end else begin : g_wire
            assign gp_q = gp_d;
            assign bp_q = bp_d;
            assign ci_q = ci_d;
            assign v_q  = v_d;
        end
    end

    // Group propagates are consumed inside the network only; the final ones are dead.
    always_comb begin
        p_unused = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            gv[i]    = bnd[L].gp_q[i].g;
            p_unused = p_unused ^ bnd[L].gp_q[i].p;
        end
    end

    assign sum = bnd[L].bp_q ^ {gv[WIDTH-2:0], bnd[L].ci_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res       <= '0;
            carry     <= 1'b0;
        end else if (en) begin
            out_valid <= bnd[L].v_q;
            res       <= sum;
            carry     <= gv[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ppa_add_pipe.sv
// tb_ppa_add_pipe: three adder configurations checked against a queue model of arithmetic and stall timing.
module tb_ppa_add_pipe;
    import ppa_pkg::*;

    localparam int W  = 74;
    localparam int ND = 3;
    localparam int LAT [ND] = '{2, 1, 14};

    typedef struct {
        logic [W:0] v;
        int         age;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, cin, sub, rdy0, bp;
    logic [W-1:0] in1, in2;
    logic         ir0, ir1, ir2, ov0, ov1, ov2, cy0, cy1, cy2;
    logic [W-1:0] rs0, rs1, rs2;

    beat_t q [ND][$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    n_out [ND] = '{0, 0, 0};
    int    cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ppa_add_pipe #(.WIDTH(W), .STAGES(2), .ARCH(ARCH_KSA)) u_ksa (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in1(in1), .in2(in2),
        .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(rdy0), .res(rs0), .carry(cy0));
    ppa_add_pipe #(.WIDTH(W), .STAGES(1), .ARCH(ARCH_SKL)) u_skl (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in1(in1), .in2(in2),
        .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(1'b1), .res(rs1), .carry(cy1));
    ppa_add_pipe #(.WIDTH(W), .STAGES(14), .ARCH(ARCH_BK)) u_bk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in1(in1), .in2(in2),
        .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(1'b1), .res(rs2), .carry(cy2));

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        return s ? {1'b1, a} - {1'b0, b} : {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    function automatic logic [W-1:0] rnd_op();
        int k = $urandom_range(0, 5);
        return k == 0 ? '1 : k == 1 ? '0 : W'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic chk(input string name, input int d, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [dut%0d]: got %h, expected %h", name, d, got, exp);
        end
    endtask

    // Reference: each accepted beat ages once per enabled edge and is due at age == latency.
    logic         m_ov [ND], m_ir [ND], m_cy [ND], m_rdy [ND];
    logic [W-1:0] m_rs [ND];
    logic         ev, en_m, stall_q = 1'b0;
    logic [W:0]   hold_q;
    beat_t        nb;

    always @(negedge clk) begin
        m_ov  = '{ov0, ov1, ov2};
        m_ir  = '{ir0, ir1, ir2};
        m_cy  = '{cy0, cy1, cy2};
        m_rs  = '{rs0, rs1, rs2};
        m_rdy = '{rdy0, 1'b1, 1'b1};
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) q[d].delete();
            ev = (q[d].size() > 0) ? (q[d][0].age == LAT[d]) : 1'b0;
            chk("out_valid", d, (W+1)'(m_ov[d]), (W+1)'(ev));
            en_m = m_rdy[d] | ~ev;
            chk("in_ready", d, (W+1)'(m_ir[d]), (W+1)'(en_m));
            if (ev) chk("result", d, {m_cy[d], m_rs[d]}, q[d][0].v);
            if (rst_n && en_m) begin
                if (ev) begin
                    q[d].delete(0);
                    n_out[d]++;
                end
                for (int i = 0; i < q[d].size(); i++) q[d][i].age = q[d][i].age + 1;
                if (in_valid) begin
                    nb.v   = model(in1, in2, cin, sub);
                    nb.age = 1;
                    q[d].push_back(nb);
                end
            end
        end
        if (stall_q && rst_n) chk("stall_hold", 0, {cy0, rs0}, hold_q);
        stall_q = rst_n & ov0 & ~rdy0;
        hold_q  = {cy0, rs0};
    end

    initial begin
        rdy0 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy0 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int n = 0;
        in1 = a;
        in2 = b;
        cin = c;
        sub = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!ir0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!ir0) begin
            $display("FAIL send_timeout: in_ready stuck at 0");
            n_fail++;
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $fatal(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [W-1:0] a, b;
        a = rnd_op();
        b = rnd_op();
        send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic expect_main(input logic [W:0] e, input int lat);
        int n = 0;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov0 && n < 40);
        chk("latency", 0, (W+1)'(n), (W+1)'(lat));
        chk("directed", 0, {cy0, rs0}, e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 0, (W+1)'(q[0].size() + q[1].size() + q[2].size()), '0);
        @(posedge clk);
        #1;
    endtask

    int base, t0;

    initial begin
        bp = 1'b0;
        in_valid = 1'b0;
        in1 = '0;
        in2 = '0;
        cin = 1'b0;
        sub = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 0, (W+1)'(ov0), '0);
        chk("reset_res", 0, {cy0, rs0}, '0);
        chk("reset_ready", 0, (W+1)'(ir0), (W+1)'(1));
        rst_n = 1'b1;

        chk("model_wrap", 0, model('1, W'(1), 1'b0, 1'b0), {1'b1, {W{1'b0}}});
        chk("model_borrow", 0, model(W'(5), W'(7), 1'b1, 1'b1), {1'b0, {(W-1){1'b1}}, 1'b0});

        send('1, W'(1), 1'b0, 1'b0);           expect_main({1'b1, {W{1'b0}}}, 2);
        send(W'(5), W'(7), 1'b1, 1'b1);        expect_main({1'b0, {(W-1){1'b1}}, 1'b0}, 2);
        send(W'(7), W'(5), 1'b0, 1'b1);        expect_main({1'b1, W'(2)}, 2);
        send(W'(3), W'(4), 1'b1, 1'b0);        expect_main({1'b0, W'(8)}, 2);
        send('1, '1, 1'b1, 1'b0);              expect_main({1'b1, {W{1'b1}}}, 2);
        send('0, '0, 1'b0, 1'b1);              expect_main({1'b1, {W{1'b0}}}, 2);
        send('0, '1, 1'b0, 1'b1);              expect_main({1'b0, W'(1)}, 2);
        drain();

        bp = 1'b1;
        repeat (10) send_rand();
        drain();

        repeat (300) send_rand();
        drain();

        bp = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        base = n_out[0];
        t0 = cyc;
        repeat (100) send_rand();
        chk("accept_cycles", 0, (W+1)'(cyc - t0), (W+1)'(100));
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("throughput", 0, (W+1)'(n_out[0] - base), (W+1)'(100));
        drain();

        repeat (3) send_rand();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 0, (W+1)'(ov0), '0);
        chk("async_res", 0, {cy0, rs0}, '0);
        chk("async_valid", 1, (W+1)'(ov1), '0);
        chk("async_res", 2, {cy2, rs2}, '0);
        chk("async_ready", 0, (W+1)'(ir0), (W+1)'(1));
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(W'(100), W'(23), 1'b0, 1'b0);     expect_main({1'b0, W'(123)}, 2);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
